// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_pkg
// Description : Shared constants and types for the exception controller:
//               MIPS ExcCode values, m_exc flag bit positions, CP0 register
//               indices, the default exception vector and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_pkg;

  // Default exception entry address
  localparam logic [31:0] c_EXC_VECTOR = 32'hBFC00380;

  // Cause.ExcCode values
  localparam logic [4:0] c_EXC_INT  = 5'h00;
  localparam logic [4:0] c_EXC_ADEL = 5'h04;
  localparam logic [4:0] c_EXC_ADES = 5'h05;
  localparam logic [4:0] c_EXC_SYS  = 5'h08;
  localparam logic [4:0] c_EXC_BP   = 5'h09;
  localparam logic [4:0] c_EXC_RI   = 5'h0A;
  localparam logic [4:0] c_EXC_OV   = 5'h0C;

  // Bit positions inside the 7-bit m_exc flag vector
  localparam int unsigned c_F_ADEL_IF = 6;
  localparam int unsigned c_F_RI      = 5;
  localparam int unsigned c_F_OV      = 4;
  localparam int unsigned c_F_SYS     = 3;
  localparam int unsigned c_F_BP      = 2;
  localparam int unsigned c_F_ADEL_LD = 1;
  localparam int unsigned c_F_ADES    = 0;

  // CP0 register indices (bit n of cp0_we strobes register n)
  localparam int unsigned c_CP0_BADVADDR = 8;
  localparam int unsigned c_CP0_STATUS   = 12;
  localparam int unsigned c_CP0_CAUSE    = 13;
  localparam int unsigned c_CP0_EPC      = 14;

  // Exception sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

endpackage : exc_pkg
`default_nettype wire

// File: rtl/exc_prio.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio
// Description : Combinational cause priority encoder. Interrupt beats every
//               synchronous exception; among the flags the order is
//               AdEL-fetch, RI, Ov, Sys, Bp, AdEL-load, AdES. Also reports
//               whether BadVAddr must be written and whether its source is
//               the PC (fetch fault) rather than the data address.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_prio
  import exc_pkg::*;
(
  input  logic       i_int_pend,
  input  logic [6:0] i_exc,
  output logic       o_exc_any,
  output logic [4:0] o_exc_code,
  output logic       o_badv_we,
  output logic       o_badv_from_pc
);

  // Priority chain: first matching term selects code and BadVAddr handling
  always_comb begin
    o_exc_any      = i_int_pend | (|i_exc);
    o_exc_code     = c_EXC_INT;
    o_badv_we      = 1'b0;
    o_badv_from_pc = 1'b0;
    if (i_int_pend) begin
      o_exc_code = c_EXC_INT;
    end else if (i_exc[c_F_ADEL_IF]) begin
      o_exc_code     = c_EXC_ADEL;
      o_badv_we      = 1'b1;
      o_badv_from_pc = 1'b1;
    end else if (i_exc[c_F_RI]) begin
      o_exc_code = c_EXC_RI;
    end else if (i_exc[c_F_OV]) begin
      o_exc_code = c_EXC_OV;
    end else if (i_exc[c_F_SYS]) begin
      o_exc_code = c_EXC_SYS;
    end else if (i_exc[c_F_BP]) begin
      o_exc_code = c_EXC_BP;
    end else if (i_exc[c_F_ADEL_LD]) begin
      o_exc_code = c_EXC_ADEL;
      o_badv_we  = 1'b1;
    end else if (i_exc[c_F_ADES]) begin
      o_exc_code = c_EXC_ADES;
      o_badv_we  = 1'b1;
    end
  end

endmodule : exc_prio
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Memory-stage exception / ERET controller. Accepts one event
//               in IDLE, strobes the CP0 writes and flush for one COMMIT
//               cycle, then holds a fetch redirect until it is accepted.
//               Build option: define EXC_CTRL_INT_EN to enable hardware
//               interrupt detection; otherwise hw_int is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(c_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  input  logic [WIDTH-1:0] m_pc,
  input  logic             m_bd,
  input  logic [WIDTH-1:0] m_badaddr,
  input  logic [6:0]       m_exc,
  input  logic             m_eret,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             redirect_ready,
  output logic [WIDTH-1:0] cp0_we,
  output logic [WIDTH-1:0] cp0_epc,
  output logic [WIDTH-1:0] cp0_badaddr,
  output logic [4:0]       cp0_exccode,
  output logic             cp0_bd,
  output logic             cp0_exl,
  output logic             flush,
  output logic             stall,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);

  // --------------------------------------------------------------------------
  // Interrupt pending term
  // --------------------------------------------------------------------------
  logic w_int_pend;

`ifdef EXC_CTRL_INT_EN
  // Enabled, unmasked line while Status.IE=1 and Status.EXL=0
  assign w_int_pend = (|(hw_int & status_in[15:10])) & status_in[0]
                      & ~status_in[1] & m_valid;
  logic w_unused_status;
  assign w_unused_status = ^{status_in[WIDTH-1:16], status_in[9:2]};
`else
  // Interrupts compiled out: Status and hw_int have no effect
  assign w_int_pend = 1'b0;
  logic w_unused_irq;
  assign w_unused_irq = ^{hw_int, status_in};
`endif

  // --------------------------------------------------------------------------
  // Cause selection
  // --------------------------------------------------------------------------
  logic       w_exc_any;
  logic [4:0] w_exc_code;
  logic       w_badv_we;
  logic       w_badv_from_pc;

  exc_prio u_prio (
    .i_int_pend     (w_int_pend),
    .i_exc          (m_exc),
    .o_exc_any      (w_exc_any),
    .o_exc_code     (w_exc_code),
    .o_badv_we      (w_badv_we),
    .o_badv_from_pc (w_badv_from_pc)
  );

  logic             w_exc_evt;
  logic             w_eret_evt;
  logic [WIDTH-1:0] w_epc;
  logic [WIDTH-1:0] w_badaddr;

  // An exception shadows an ERET presented in the same cycle
  assign w_exc_evt  = m_valid & w_exc_any;
  assign w_eret_evt = m_valid & m_eret & ~w_exc_evt;
  // Delay-slot instructions restart at the branch; wraps naturally at 0
  assign w_epc      = m_bd ? (m_pc - WIDTH'(4)) : m_pc;
  assign w_badaddr  = w_badv_we ? (w_badv_from_pc ? m_pc : m_badaddr) : '0;

  // CP0 write-strobe patterns for the two kinds of event
  logic [WIDTH-1:0] w_we_exc;
  logic [WIDTH-1:0] w_we_eret;

  // Build strobe vectors from the register indices
  always_comb begin
    w_we_exc                  = '0;
    w_we_exc[c_CP0_STATUS]    = 1'b1;
    w_we_exc[c_CP0_CAUSE]     = 1'b1;
    w_we_exc[c_CP0_EPC]       = 1'b1;
    w_we_exc[c_CP0_BADVADDR]  = w_badv_we;
    w_we_eret                 = '0;
    w_we_eret[c_CP0_STATUS]   = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // --------------------------------------------------------------------------
  exc_state_e       state_q, state_d;
  logic [WIDTH-1:0] cp0_we_q, cp0_we_d;
  logic [WIDTH-1:0] cp0_epc_q, cp0_epc_d;
  logic [WIDTH-1:0] cp0_badaddr_q, cp0_badaddr_d;
  logic [4:0]       cp0_exccode_q, cp0_exccode_d;
  logic             cp0_bd_q, cp0_bd_d;
  logic             cp0_exl_q, cp0_exl_d;
  logic             flush_q, flush_d;
  logic             stall_q, stall_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  // Next-state and next-output logic; strobes are single-cycle pulses
  always_comb begin
    state_d          = state_q;
    cp0_we_d         = '0;
    flush_d          = 1'b0;
    cp0_epc_d        = cp0_epc_q;
    cp0_badaddr_d    = cp0_badaddr_q;
    cp0_exccode_d    = cp0_exccode_q;
    cp0_bd_d         = cp0_bd_q;
    cp0_exl_d        = cp0_exl_q;
    stall_d          = stall_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (w_exc_evt) begin
          state_d       = ST_COMMIT;
          cp0_we_d      = w_we_exc;
          flush_d       = 1'b1;
          stall_d       = 1'b1;
          cp0_epc_d     = w_epc;
          cp0_badaddr_d = w_badaddr;
          cp0_exccode_d = w_exc_code;
          cp0_bd_d      = m_bd;
          cp0_exl_d     = 1'b1;
          redirect_pc_d = EXC_VECTOR;
        end else if (w_eret_evt) begin
          state_d       = ST_COMMIT;
          cp0_we_d      = w_we_eret;
          flush_d       = 1'b1;
          stall_d       = 1'b1;
          cp0_epc_d     = epc_in;
          cp0_badaddr_d = '0;
          cp0_exccode_d = '0;
          cp0_bd_d      = 1'b0;
          cp0_exl_d     = 1'b0;
          redirect_pc_d = epc_in;
        end
      end
      ST_COMMIT: begin
        state_d          = ST_REDIRECT;
        stall_d          = 1'b1;
        redirect_valid_d = 1'b1;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d          = ST_IDLE;
          stall_d          = 1'b0;
          redirect_valid_d = 1'b0;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        stall_d          = 1'b0;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cp0_we_q         <= '0;
      cp0_epc_q        <= '0;
      cp0_badaddr_q    <= '0;
      cp0_exccode_q    <= '0;
      cp0_bd_q         <= 1'b0;
      cp0_exl_q        <= 1'b0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cp0_we_q         <= cp0_we_d;
      cp0_epc_q        <= cp0_epc_d;
      cp0_badaddr_q    <= cp0_badaddr_d;
      cp0_exccode_q    <= cp0_exccode_d;
      cp0_bd_q         <= cp0_bd_d;
      cp0_exl_q        <= cp0_exl_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign cp0_we         = cp0_we_q;
  assign cp0_epc        = cp0_epc_q;
  assign cp0_badaddr    = cp0_badaddr_q;
  assign cp0_exccode    = cp0_exccode_q;
  assign cp0_bd         = cp0_bd_q;
  assign cp0_exl        = cp0_exl_q;
  assign flush          = flush_q;
  assign stall          = stall_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule : exc_ctrl
`default_nettype wire

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data/address width.
REQ-002 Parameter EXC_VECTOR, default 32'hBFC00380: exception entry address.
REQ-003 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  async active-high reset.
REQ-006 m_valid  in  1  memory-stage instruction valid.
REQ-007 m_pc  in  WIDTH  memory-stage PC.
REQ-008 m_bd  in  1  instruction sits in a branch delay slot.
REQ-009 m_badaddr  in  WIDTH  faulting virtual address.
REQ-010 m_exc  in  7  flags {adel_if, ri, ov, sys, bp, adel_ld, ades}, bit6..bit0.
REQ-011 m_eret  in  1  ERET in memory stage.
REQ-012 hw_int  in  6  hardware interrupt lines.
REQ-013 status_in, epc_in  in  WIDTH each  live CP0 Status and EPC.
REQ-014 redirect_ready  in  1  fetch accepts the redirect.
REQ-015 cp0_we  out  WIDTH  per-register CP0 write strobe, bit n = register n.
REQ-016 cp0_epc, cp0_badaddr  out  WIDTH each  EPC and BadVAddr write data.
REQ-017 cp0_exccode  out  5 / cp0_bd  out  1 / cp0_exl  out  1  Cause/Status write data.
REQ-018 flush  out  1  kill all younger pipeline stages.
REQ-019 stall  out  1  freeze the memory stage and everything upstream.
REQ-020 redirect_valid  out  1 / redirect_pc  out  WIDTH  fetch redirect.

Function
REQ-021 Interrupt pending: |(hw_int & status_in[15:10]) & status_in[0] & ~status_in[1] & m_valid.
REQ-022 Cause priority, highest first: Int 0x00, AdEL-fetch 0x04, RI 0x0A, Ov 0x0C, Sys 0x08, Bp 0x09, AdEL-load 0x04, AdES 0x05.
REQ-023 BadVAddr is written only for the AdEL and AdES causes; cp0_badaddr carries m_pc for fetch faults and m_badaddr for data faults.
REQ-024 EPC is m_pc-4 when m_bd=1, otherwise m_pc; the subtraction wraps modulo 2^WIDTH.
REQ-025 FSM states: IDLE, COMMIT, REDIRECT; the FSM accepts an event only in IDLE.
REQ-026 IDLE->COMMIT on any exception or ERET; all event fields are latched at that edge.
REQ-027 COMMIT lasts exactly 1 cycle, then goes to REDIRECT.
REQ-028 COMMIT for an exception: cp0_we bits 12, 13 and 14 are set, plus bit 8 when BadVAddr is written; cp0_exl=1; flush=1.
REQ-029 COMMIT for ERET: cp0_we[12]=1, cp0_exl=0, flush=1; redirect_pc = epc_in sampled at acceptance.
REQ-030 An exception has priority over an ERET in the same cycle; the ERET is discarded.
REQ-031 REDIRECT holds redirect_valid=1 with a stable redirect_pc (EXC_VECTOR for exceptions) until redirect_ready=1; it returns to IDLE on that edge.
REQ-032 stall=1 in COMMIT and REDIRECT; cp0_we=0 and flush=0 outside COMMIT.
REQ-033 Latency: event at cycle T; CP0 strobes and flush at T+1; redirect_valid first at T+2.
REQ-034 Events presented in non-IDLE states are ignored; the upstream stall keeps them held.

Reset
REQ-035 rst forces IDLE asynchronously and clears all latched fields.
REQ-036 All outputs read 0 during and after reset.
REQ-037 Reset asserted in COMMIT or REDIRECT aborts the sequence with no CP0 write.

Configuration
REQ-038 Macro EXC_CTRL_INT_EN defined: interrupt detection per REQ-021.
REQ-039 EXC_CTRL_INT_EN undefined: the interrupt term is tied to 0 and hw_int is unused.

Structure
REQ-040 A shared package exc_pkg holds the ExcCode constants, the FSM state typedef, EXC_VECTOR and the CP0 register index constants (8, 12, 13, 14).
REQ-041 One sub-module, exc_prio: a combinational priority encoder that outputs the cause code and a BadVAddr-write flag.

Verification
REQ-042 ov at m_pc=0x80001000, m_bd=0 -> at T+1 cp0_we=0x7000, exccode=0x0C, epc=0x80001000, flush=1; at T+2 redirect_pc=0xBFC00380.
REQ-043 adel_ld with m_badaddr=0x00000003, m_bd=1, m_pc=0x80000010 -> cp0_we=0x7100, badaddr=0x3, epc=0x8000000C, bd=1.
REQ-044 ri and sys both set -> exccode=0x0A; hw_int=6'b000001 with status_in=0x00000401 -> exccode=0x00, interrupt wins.
REQ-045 ERET with epc_in=0x80002000 -> cp0_we=0x1000, cp0_exl=0; redirect_pc=0x80002000 held for 3 cycles while redirect_ready=0.
REQ-046 rst pulsed in REDIRECT -> next cycle redirect_valid=0, stall=0, state IDLE.
REQ-047 Build without EXC_CTRL_INT_EN, hw_int=6'h3F, status_in=0xFC01 -> no event; stall stays 0.
